// File: rtl/gen_tptn_mc.sv
// Multi-tap Camera Link test-pattern source: programmable blanking, five patterns, frame counter, bounded bursts.
// Outputs are registered from the next-state decode so they line up with the FSM state; stops wait for a frame boundary.
module gen_tptn_mc #(
  parameter int DW        = 8,
  parameter int NTAP      = 2,
  parameter int L_LEN     = 32,
  parameter int H_LEN     = 24,
  parameter int INT_H     = 2,
  parameter int INT_LINE  = 2,
  parameter int INT_LR_DR = 1,
  parameter int INT_DF_LF = 2,
  parameter logic [DW-1:0] TPTN_A = 8'h55,
  parameter logic [DW-1:0] TPTN_B = 8'hAA
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en,
  input  logic [2:0]               mode,
  input  logic [15:0]              nframes,
  output logic                     busy,
  output logic                     frame_done,
  output logic [15:0]              frame_cnt,
  output logic [3+NTAP*DW-1:0]     dot
);

  localparam int LB      = L_LEN / NTAP;
  localparam int ACT_LEN = INT_LR_DR + LB;

  typedef enum logic [2:0] {IDLE, VBLK, LPRE, LACT, LPOST} state_t;

  // A zero-length pre-line gap jumps straight into the active phase.
  localparam state_t LINE_START = (INT_LINE > 0) ? LPRE : LACT;

  state_t             state, state_n;
  logic [15:0]        cnt, cnt_n, line, line_n;
  logic               mode_ld, frame_end, line_end;
  logic [2:0]         mode_q, mode_n;
  logic [DW-1:0]      f_q, f_n;
  logic [15:0]        burst_q, done_q;
  logic               busy_d, fd_d, fval_d, lval_d, dval_d;
  logic [NTAP*DW-1:0] taps_d;
  logic [DW-1:0]      beat, x, y, g, px;

  function automatic logic last_cycle(state_t s, logic [15:0] c, logic [15:0] l);
    if (INT_DF_LF > 0)
      return (s == LPOST) && (c == 16'(INT_DF_LF-1)) && (l == 16'(H_LEN-1));
    return (s == LACT) && (c == 16'(ACT_LEN-1)) && (l == 16'(H_LEN-1));
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    line_n    = line;
    mode_ld   = 1'b0;
    frame_end = 1'b0;
    line_end  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (en) state_n = VBLK;
      end
      VBLK: begin
        if (cnt == 16'(INT_H-1)) begin
          cnt_n   = '0;
          mode_ld = 1'b1;
          state_n = LINE_START;
        end
      end
      LPRE: begin
        if (cnt == 16'(INT_LINE-1)) begin
          cnt_n   = '0;
          state_n = LACT;
        end
      end
      LACT: begin
        if (cnt == 16'(ACT_LEN-1)) begin
          cnt_n = '0;
          if (INT_DF_LF > 0) state_n = LPOST;
          else               line_end = 1'b1;
        end
      end
      LPOST: begin
        if (cnt == 16'(INT_DF_LF-1)) line_end = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (line_end) begin
      cnt_n = '0;
      if (line != 16'(H_LEN-1)) begin
        line_n  = line + 16'd1;
        state_n = LINE_START;
      end else begin
        frame_end = 1'b1;
        line_n    = '0;
        state_n   = (!en || (burst_q != '0 && done_q + 16'd1 == burst_q)) ? IDLE : VBLK;
      end
    end
  end

  always_comb begin
    mode_n = mode_ld ? mode : mode_q;
    f_n    = mode_ld ? DW'(frame_cnt) : f_q;
    busy_d = (state_n != IDLE);
    fval_d = (state_n == LPRE) || (state_n == LACT) || (state_n == LPOST);
    lval_d = (state_n == LACT) || (state_n == LPOST);
    dval_d = (state_n == LACT) && (cnt_n >= 16'(INT_LR_DR));
    fd_d   = last_cycle(state_n, cnt_n, line_n);
    beat   = DW'(cnt_n - 16'(INT_LR_DR));
    y      = DW'(line_n);
    x      = '0;
    g      = '0;
    px     = '0;
    taps_d = '0;
    if (dval_d) begin
      for (int k = 0; k < NTAP; k++) begin
        x = beat * DW'(NTAP) + DW'(k);
        g = y * DW'(L_LEN) + x;
        case (mode_n)
          3'd1:    px = x;
          3'd2:    px = y;
          3'd3:    px = x + y + f_n;
          3'd4:    px = TPTN_A;
          default: px = g[0] ? TPTN_B : TPTN_A;
        endcase
        taps_d[k*DW +: DW] = px;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      line       <= '0;
      mode_q     <= '0;
      f_q        <= '0;
      burst_q    <= '0;
      done_q     <= '0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dot        <= '0;
    end else begin
      cnt    <= cnt_n;
      line   <= line_n;
      mode_q <= mode_n;
      f_q    <= f_n;
      if (state == IDLE && en) begin
        burst_q <= nframes;
        done_q  <= '0;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
        done_q    <= done_q + 16'd1;
      end
      busy       <= busy_d;
      frame_done <= fd_d;
      dot        <= {dval_d, fval_d, lval_d, taps_d};
    end
  end

endmodule

// File: tb/tb_gen_tptn_mc.sv
// Bench for gen_tptn_mc: frame-position reference model plus scenario-specific timing and pattern checks.
module tb_gen_tptn_mc;

  localparam int DW = 8, NTAP = 2, L_LEN = 8, H_LEN = 3;
  localparam int INT_H = 2, INT_LINE = 2, INT_LR_DR = 1, INT_DF_LF = 2;
  localparam logic [7:0] TA = 8'h55, TB = 8'hAA;
  localparam int LB = L_LEN / NTAP;
  localparam int LPIX = INT_LINE + INT_LR_DR + LB + INT_DF_LF;
  localparam int FRAME = INT_H + H_LEN * LPIX;
  localparam int DOTW = 3 + NTAP * DW;

  logic CLK = 1'b0;
  logic RST, en;
  logic [2:0] mode;
  logic [15:0] nframes;
  logic busy, frame_done;
  logic [15:0] frame_cnt;
  logic [DOTW-1:0] dot;

  int checks = 0;
  int fails = 0;

  bit m_busy;
  int m_pos;
  logic [15:0] m_fcnt, m_done, m_burst;
  logic [2:0] m_mode;
  logic [7:0] m_f;
  logic e_fd;
  logic [DOTW-1:0] e_dot;

  always #5 CLK = ~CLK;

  gen_tptn_mc #(
    .DW(DW), .NTAP(NTAP), .L_LEN(L_LEN), .H_LEN(H_LEN), .INT_H(INT_H),
    .INT_LINE(INT_LINE), .INT_LR_DR(INT_LR_DR), .INT_DF_LF(INT_DF_LF),
    .TPTN_A(TA), .TPTN_B(TB)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .mode(mode), .nframes(nframes),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt), .dot(dot)
  );

  // Expected {dval,fval,lval,taps} at a given cycle position inside a frame.
  function automatic logic [DOTW-1:0] exp_dot(bit b, int pos, logic [2:0] md, logic [7:0] f);
    logic [DOTW-1:0] r;
    logic [DW-1:0] px;
    int q, y, c, bt, x, g;
    r = '0;
    if (b && pos >= INT_H) begin
      q = pos - INT_H;
      y = q / LPIX;
      c = q % LPIX;
      r[DOTW-2] = 1'b1;
      r[DOTW-3] = (c >= INT_LINE);
      if (c >= INT_LINE + INT_LR_DR && c < INT_LINE + INT_LR_DR + LB) begin
        r[DOTW-1] = 1'b1;
        bt = c - INT_LINE - INT_LR_DR;
        for (int k = 0; k < NTAP; k++) begin
          x = bt * NTAP + k;
          g = y * L_LEN + x;
          case (md)
            3'd1:    px = DW'(x);
            3'd2:    px = DW'(y);
            3'd3:    px = DW'(x + y + int'(f));
            3'd4:    px = TA;
            default: px = (g % 2 == 0) ? TA : TB;
          endcase
          r[k*DW +: DW] = px;
        end
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    int old;
    if (RST) begin
      m_busy = 0; m_pos = 0; m_fcnt = '0; m_done = '0; m_burst = '0; m_mode = '0; m_f = '0;
    end else if (!m_busy) begin
      if (en) begin
        m_busy = 1; m_pos = 0; m_burst = nframes; m_done = '0;
      end
    end else begin
      old = m_pos;
      if (old == INT_H - 1) begin
        m_mode = mode;
        m_f = m_fcnt[7:0];
      end
      if (old == FRAME - 1) begin
        m_fcnt = m_fcnt + 16'd1;
        m_done = m_done + 16'd1;
        if (!en || (m_burst != 0 && m_done == m_burst)) m_busy = 0;
        m_pos = 0;
      end else begin
        m_pos = old + 1;
      end
    end
    e_dot = exp_dot(m_busy, m_pos, m_mode, m_f);
    e_fd  = m_busy && (m_pos == FRAME - 1);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; en = 1'b0; mode = '0; nframes = '0;
    tick();
    tick();
    checks++;
    if (dot !== '0) begin fails++; $display("FAIL reset_dot: got %h want 0", dot); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
    checks++;
    if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    RST = 1'b0;
  endtask

  task automatic test_alt();
    int nf = 0, nl = 0, nd = 0, nfd = 0, tb = -1, tf = -1, badtap = 0;
    en = 1'b1; mode = 3'd0; nframes = 16'd1;
    for (int t = 0; t < 40; t++) begin
      tick();
      checks++;
      if ({busy, frame_done, frame_cnt, dot} !== {m_busy, e_fd, m_fcnt, e_dot}) begin
        fails++;
        $display("FAIL alt_cycle t=%0d: got b=%b fd=%b cnt=%0d dot=%h want b=%b fd=%b cnt=%0d dot=%h",
                 t, busy, frame_done, frame_cnt, dot, m_busy, e_fd, m_fcnt, e_dot);
      end
      if (busy && tb < 0) tb = t;
      if (dot[DOTW-2] && tf < 0) tf = t;
      if (dot[DOTW-2]) nf++;
      if (dot[DOTW-3]) nl++;
      if (dot[DOTW-1]) begin
        nd++;
        if (dot[15:0] !== 16'hAA55) badtap++;
      end
      if (frame_done) nfd++;
      if (t > 0 && !m_busy) en = 1'b0;
    end
    checks++;
    if (tb !== 0) begin fails++; $display("FAIL alt_busy_rise: got %0d want 0", tb); end
    checks++;
    if (tf - tb !== 2) begin fails++; $display("FAIL alt_fval_delay: got %0d want 2", tf - tb); end
    checks++;
    if (nf !== 27) begin fails++; $display("FAIL alt_fval_len: got %0d want 27", nf); end
    checks++;
    if (nl !== 21) begin fails++; $display("FAIL alt_lval_len: got %0d want 21", nl); end
    checks++;
    if (nd !== 12 || badtap !== 0) begin fails++; $display("FAIL alt_dval: got %0d beats %0d bad want 12 beats 0 bad", nd, badtap); end
    checks++;
    if (nfd !== 1 || frame_cnt !== 16'd1 || busy !== 1'b0) begin
      fails++; $display("FAIL alt_end: got fd=%0d cnt=%0d busy=%b want 1 1 0", nfd, frame_cnt, busy);
    end
  endtask

  task automatic test_ramps();
    logic [15:0] first_exp [2];
    logic [15:0] last_exp [2];
    logic [15:0] first_t, last_t;
    bit seen;
    first_exp[0] = 16'h0100; last_exp[0] = 16'h0706;
    first_exp[1] = 16'h0000; last_exp[1] = 16'h0202;
    for (int mi = 0; mi < 2; mi++) begin
      en = 1'b1; mode = 3'(mi + 1); nframes = 16'd1; seen = 0; first_t = '0; last_t = '0;
      for (int t = 0; t < 32; t++) begin
        tick();
        checks++;
        if ({busy, frame_done, frame_cnt, dot} !== {m_busy, e_fd, m_fcnt, e_dot}) begin
          fails++;
          $display("FAIL ramp_cycle m=%0d t=%0d: got b=%b cnt=%0d dot=%h want b=%b cnt=%0d dot=%h",
                   mi + 1, t, busy, frame_cnt, dot, m_busy, m_fcnt, e_dot);
        end
        if (dot[DOTW-1]) begin
          if (!seen) first_t = dot[15:0];
          seen = 1;
          last_t = dot[15:0];
        end
        if (t > 0 && !m_busy) en = 1'b0;
      end
      checks++;
      if (first_t !== first_exp[mi] || last_t !== last_exp[mi]) begin
        fails++;
        $display("FAIL ramp_taps m=%0d: got first=%h last=%h want %h %h", mi + 1, first_t, last_t, first_exp[mi], last_exp[mi]);
      end
    end
  endtask

  task automatic test_diag_burst();
    int nb = 0, nd = 0;
    logic [15:0] cap = '0;
    RST = 1'b1; tick(); RST = 1'b0;
    en = 1'b1; mode = 3'd3; nframes = 16'd3;
    for (int t = 0; t < 95; t++) begin
      tick();
      checks++;
      if ({busy, frame_done, frame_cnt, dot} !== {m_busy, e_fd, m_fcnt, e_dot}) begin
        fails++;
        $display("FAIL diag_cycle t=%0d: got b=%b fd=%b cnt=%0d dot=%h want b=%b fd=%b cnt=%0d dot=%h",
                 t, busy, frame_done, frame_cnt, dot, m_busy, e_fd, m_fcnt, e_dot);
      end
      if (busy) nb++;
      if (dot[DOTW-1]) begin
        if (nd == 28) cap = dot[15:0];
        nd++;
      end
      if (t > 0 && !m_busy) en = 1'b0;
    end
    checks++;
    if (cap !== 16'h0403) begin fails++; $display("FAIL diag_f2_l1_b0: got %h want 0403", cap); end
    checks++;
    if (nb !== 87 || frame_cnt !== 16'd3) begin
      fails++; $display("FAIL diag_burst: got busy=%0d cnt=%0d want 87 3", nb, frame_cnt);
    end
  endtask

  task automatic test_en_drop();
    int nb = 0;
    RST = 1'b1; tick(); RST = 1'b0;
    en = 1'b1; mode = 3'($urandom_range(0, 7)); nframes = 16'd0;
    for (int t = 0; t < 70; t++) begin
      tick();
      checks++;
      if ({busy, frame_done, frame_cnt, dot} !== {m_busy, e_fd, m_fcnt, e_dot}) begin
        fails++;
        $display("FAIL endrop_cycle t=%0d: got b=%b cnt=%0d dot=%h want b=%b cnt=%0d dot=%h",
                 t, busy, frame_cnt, dot, m_busy, m_fcnt, e_dot);
      end
      if (busy) nb++;
      if (t == 40) en = 1'b0;
      if (t == 45) nframes = 16'd1;
    end
    checks++;
    if (nb !== 58 || frame_cnt !== 16'd2) begin
      fails++; $display("FAIL endrop_graceful: got busy=%0d cnt=%0d want 58 2", nb, frame_cnt);
    end
  endtask

  task automatic test_mode_change();
    int n1 = 0, n2 = 0;
    RST = 1'b1; tick(); RST = 1'b0;
    en = 1'b1; mode = 3'd0; nframes = 16'd2;
    for (int t = 0; t < 62; t++) begin
      tick();
      checks++;
      if ({busy, frame_done, frame_cnt, dot} !== {m_busy, e_fd, m_fcnt, e_dot}) begin
        fails++;
        $display("FAIL modechg_cycle t=%0d: got b=%b cnt=%0d dot=%h want b=%b cnt=%0d dot=%h",
                 t, busy, frame_cnt, dot, m_busy, m_fcnt, e_dot);
      end
      if (dot[DOTW-1] && t < FRAME && dot[15:0] === 16'hAA55) n1++;
      if (dot[DOTW-1] && t >= FRAME && dot[15:0] === 16'h5555) n2++;
      if (t == 10) mode = 3'd4;
      if (t > 0 && !m_busy) en = 1'b0;
    end
    checks++;
    if (n1 !== 12 || n2 !== 12) begin
      fails++; $display("FAIL modechg_frames: got alt=%0d fixed=%0d want 12 12", n1, n2);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] fv;
    logic [2:0] bz;
    en = 1'b1; mode = 3'd2; nframes = 16'd0;
    for (int t = 0; t < FRAME + 6; t++) begin
      tick();
      checks++;
      if ({busy, frame_done, frame_cnt, dot} !== {m_busy, e_fd, m_fcnt, e_dot}) begin
        fails++;
        $display("FAIL rstmid_pre t=%0d: got b=%b cnt=%0d dot=%h want b=%b cnt=%0d dot=%h",
                 t, busy, frame_cnt, dot, m_busy, m_fcnt, e_dot);
      end
    end
    RST = 1'b1; tick(); RST = 1'b0;
    checks++;
    if (dot !== '0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      fails++; $display("FAIL rstmid_clear: got dot=%h busy=%b cnt=%0d want 0 0 0", dot, busy, frame_cnt);
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      fv[t] = dot[DOTW-2];
      bz[t] = busy;
    end
    checks++;
    if (fv !== 3'b100 || bz !== 3'b111) begin
      fails++; $display("FAIL rstmid_restart: got fval=%b busy=%b want 100 111", fv, bz);
    end
    en = 1'b0;
    for (int t = 0; t < FRAME; t++) begin
      tick();
      checks++;
      if ({busy, frame_done, frame_cnt, dot} !== {m_busy, e_fd, m_fcnt, e_dot}) begin
        fails++;
        $display("FAIL rstmid_post t=%0d: got b=%b cnt=%0d dot=%h want b=%b cnt=%0d dot=%h",
                 t, busy, frame_cnt, dot, m_busy, m_fcnt, e_dot);
      end
    end
  endtask

  task automatic test_random();
    int drop;
    for (int it = 0; it < 6; it++) begin
      drop = $urandom_range(1, 80);
      nframes = 16'($urandom_range(0, 3));
      for (int t = 0; t < 120; t++) begin
        en = (t < drop);
        if (t % 13 == 0) mode = 3'($urandom_range(0, 7));
        tick();
        checks++;
        if ({busy, frame_done, frame_cnt, dot} !== {m_busy, e_fd, m_fcnt, e_dot}) begin
          fails++;
          $display("FAIL rand_cycle it=%0d t=%0d: got b=%b fd=%b cnt=%0d dot=%h want b=%b fd=%b cnt=%0d dot=%h",
                   it, t, busy, frame_done, frame_cnt, dot, m_busy, e_fd, m_fcnt, e_dot);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; mode = '0; nframes = '0;
    m_busy = 0; m_pos = 0; m_fcnt = '0; m_done = '0; m_burst = '0; m_mode = '0; m_f = '0;
    e_fd = 1'b0; e_dot = '0;
    test_reset();
    test_alt();
    test_ramps();
    test_diag_burst();
    test_en_drop();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
